regfile_mp_sb: RTL

- Parametrised multi-port integer register file for superscalar and pipelined cores.
- Provides NRD combinational read ports, NWR write-back ports with write-to-read bypass, and a per-register pending scoreboard for RAW hazard detection.
- Provides a registered debug snapshot of the whole array.
- Sits between decode/issue (reads, issue marks) and write-back (writes, pending clears).

---
 rtl/regfile_mp_sb.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass, a per-register
// pending scoreboard for RAW hazard detection, and a registered debug snapshot.
module regfile_mp_sb #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int SP_IDX  = 2,
  parameter int SP_INIT = 2048,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic                 flush,
  output logic [NREG*XLEN-1:0] dbg_regs
);

  if (NRD < 1 || NWR < 1 || SP_IDX >= NREG || NREG < 2 || (NREG & (NREG - 1)) != 0)
  begin : g_param_check
    $error("regfile_mp_sb: illegal parameter combination");
  end

  logic [XLEN-1:0]      regs_q [NREG];
  logic [NREG-1:0]      pending_q;
  logic [NREG-1:0]      pending_d;
  logic [NREG-1:0]      wb_hit;
  logic [NREG*XLEN-1:0] dbg_q;

  // wb_hit[k]: some enabled write port targets register k this cycle.
  always_comb begin
    wb_hit = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) wb_hit[wr_addr[j*AW +: AW]] = 1'b1;
    end
  end

  // A new issue overrides a same-cycle write-back clear; flush overrides both.
  always_comb begin
    pending_d = pending_q & ~wb_hit;
    if (iss_en && iss_addr != '0) pending_d[iss_addr] = 1'b1;
    if (flush) pending_d = '0;
    pending_d[0] = 1'b0;
  end

  // Later write ports are scanned last so the highest index wins the bypass.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rstn && rd_en && rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
        end
        rd_busy[i] = pending_q[rd_addr[i*AW +: AW]] & ~wb_hit[rd_addr[i*AW +: AW]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NREG; k++)
        regs_q[k] <= (k == SP_IDX && k != 0) ? XLEN'(SP_INIT) : '0;
      pending_q <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
          regs_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
      pending_q <= pending_d;
    end
  end

  // Snapshot shows the array as it stood before this edge's writes.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREG; k++) begin
      if (!rstn)
        dbg_q[k*XLEN +: XLEN] <= (k == SP_IDX && k != 0) ? XLEN'(SP_INIT) : '0;
      else
        dbg_q[k*XLEN +: XLEN] <= regs_q[k];
    end
  end

  assign dbg_regs = dbg_q;

endmodule
